msrv32_rf_wr_arbiter: RTL

Write-port arbiter for the 32x32 integer register file. Several producers (ALU writeback, load unit, CSR unit) share the register file's single write port (`wr_en`/`rd_addr`/`rd`). The block picks one valid requester per cycle with a valid/ready handshake and registers the winner onto the write port. It sits between the execute/memory stages and the register file.

---
 rtl/msrv32_pkg.sv | 16 +
 rtl/msrv32_rr_picker.sv | 47 ++++
 rtl/msrv32_rf_wr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// -----------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the msrv32 core slice: register-file geometry and the
// fixed requester slots on the register-file write-port arbiter.
// -----------------------------------------------------------------------------
package msrv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // Requester slot assignment on the write-port arbiter
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_CSR  = 2;

endpackage

// File: rtl/msrv32_rr_picker.sv
// -----------------------------------------------------------------------------
// msrv32_rr_picker
// Combinational one-hot picker: grants the first set bit of valid_in at or
// after index ptr_in, wrapping around to index 0. With ptr_in tied to zero it
// degenerates to a lowest-index-wins fixed-priority picker.
//
// Ports
//   valid_in  [N-1:0]   request vector
//   ptr_in    [PW-1:0]  starting index of the search
//   grant_out [N-1:0]   one-hot winner, all-zero when valid_in is zero
// -----------------------------------------------------------------------------
module msrv32_rr_picker #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid_in,
  input  logic [PW-1:0] ptr_in,
  output logic [N-1:0]  grant_out
);

  logic [N-1:0] upper_valid;
  logic [N-1:0] upper_grant;
  logic [N-1:0] lower_grant;

  // Requests at or above the pointer take precedence; if there are none the
  // search wraps and the lowest valid index overall wins.
  always_comb begin
    upper_valid = '0;
    upper_grant = '0;
    lower_grant = '0;
    for (int i = 0; i < N; i++) begin
      upper_valid[i] = valid_in[i] && (i >= int'(ptr_in));
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (upper_valid[i]) begin
        upper_grant    = '0;
        upper_grant[i] = 1'b1;
      end
      if (valid_in[i]) begin
        lower_grant    = '0;
        lower_grant[i] = 1'b1;
      end
    end
    grant_out = (|upper_valid) ? upper_grant : lower_grant;
  end

endmodule

// File: rtl/msrv32_rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// msrv32_rf_wr_arbiter
// Shares the integer register file's single write port between the ALU
// writeback, load unit and CSR unit. One valid requester is granted per cycle
// through a combinational valid/ready handshake and the winner's write is
// registered onto the write port on the following edge.
//
// Build option
//   MSRV32_RF_ARB_RR_EN  defined   : round-robin arbitration (rotating pointer)
//                        undefined : fixed priority, lowest index wins
//
// Ports
//   ms_riscv32_mp_clk_in  clock, rising edge
//   ms_riscv32_mp_rst_in  asynchronous active-high reset
//   req_valid_in          per-requester write request
//   req_addr_in           packed destination registers, 5 bits per requester
//   req_data_in           packed write data, 32 bits per requester
//   req_ready_out         grant, one-hot or zero
//   stall_in              pipeline hold, blocks all grants
//   wr_en_out             register-file write enable
//   rd_addr_out           register-file write address
//   rd_out                register-file write data
//   grant_id_out          index of the requester whose write is on the port
//   busy_out              some request is valid but not transferred this cycle
// -----------------------------------------------------------------------------
module msrv32_rf_wr_arbiter
  import msrv32_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic                          ms_riscv32_mp_clk_in,
  input  logic                          ms_riscv32_mp_rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr_in,
  input  logic [XLEN*NUM_REQ-1:0]       req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic                          stall_in,
  output logic                          wr_en_out,
  output logic [REG_ADDR_W-1:0]         rd_addr_out,
  output logic [XLEN-1:0]               rd_out,
  output logic [GID_W-1:0]              grant_id_out,
  output logic                          busy_out
);

  logic [NUM_REQ-1:0]    grant;
  logic [GID_W-1:0]      ptr;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;
  logic [GID_W-1:0]      sel_id;

  logic                  wr_en_q,    wr_en_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [XLEN-1:0]       rd_q,       rd_d;
  logic [GID_W-1:0]      grant_id_q, grant_id_d;

`ifdef MSRV32_RF_ARB_RR_EN
  logic [GID_W-1:0]      ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  msrv32_rr_picker #(
    .N  (NUM_REQ),
    .PW (GID_W)
  ) u_picker (
    .valid_in  (req_valid_in),
    .ptr_in    (ptr),
    .grant_out (grant)
  );

  // The picker only ever grants valid bits, so ready never rises on an idle
  // requester and any set ready bit is a transfer.
  always_comb begin
    req_ready_out = stall_in ? '0 : grant;
    xfer          = |req_ready_out;
    busy_out      = (|req_valid_in) && !xfer;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_out[i]) begin
        sel_addr = req_addr_in[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data_in[i*XLEN +: XLEN];
        sel_id   = GID_W'(i);
      end
    end
  end

  // A write to x0 completes its handshake but never raises wr_en.
  always_comb begin
    wr_en_d    = xfer && (sel_addr != '0);
    rd_addr_d  = xfer ? sel_addr : rd_addr_q;
    rd_d       = xfer ? sel_data : rd_q;
    grant_id_d = xfer ? sel_id   : grant_id_q;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_q       <= '0;
      grant_id_q <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_q       <= rd_d;
      grant_id_q <= grant_id_d;
    end
  end

`ifdef MSRV32_RF_ARB_RR_EN
  // Pointer moves one past the winner so that winner has lowest priority next.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (int'(sel_id) == NUM_REQ - 1) ? '0 : sel_id + 1'b1;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign wr_en_out    = wr_en_q;
  assign rd_addr_out  = rd_addr_q;
  assign rd_out       = rd_q;
  assign grant_id_out = grant_id_q;

endmodule
